muldiv_unit: RTL

Iterative HI/LO multiply/divide unit for the mips789 core. It sits directly downstream of the register file: it consumes the two read-port operands (rs on `a`, rt on `b`) during execute and holds the architectural HI/LO registers. It drives `busy` back to the pipeline controller so MFHI/MFLO and new mult/div ops stall until results are ready. The unit is shift-add / restoring-divide, one bit per cycle.

---
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit for the mips789 core.
// Shift-add multiply and restoring divide, one bit per cycle, with
// sign correction applied in a final FIX cycle. HI/LO are architectural
// state and are read through dout, which is a combinational mux.
// Optional build macro: MULDIV_FAST_MUL_EN selects a single-cycle multiplier
// for MULT/MULTU; divide stays iterative.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        rd_sel,
  output logic [31:0] dout,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] op_b;     // multiplicand or divisor magnitude
  logic [63:0] acc;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic        is_div;
  logic        neg_q;    // sign of product (mult) or quotient (div)
  logic        neg_r;    // sign of remainder (div only)

  logic        is_signed_op;
  logic        is_mul_op;
  logic        is_div_op;
  logic        accept;
  logic        start;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic [63:0] acc_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Operand decode: magnitudes for signed ops and the accept/start qualifiers.
  always_comb begin
    is_signed_op = (ctl == OP_MULT) || (ctl == OP_DIV);
    is_mul_op    = (ctl == OP_MULT) || (ctl == OP_MULTU);
    is_div_op    = (ctl == OP_DIV)  || (ctl == OP_DIVU);
    a_mag        = (is_signed_op && a[31]) ? -a : a;
    b_mag        = (is_signed_op && b[31]) ? -b : b;
    accept       = (state == IDLE) && !flush;
`ifdef MULDIV_FAST_MUL_EN
    start        = accept && is_div_op;
`else
    start        = accept && (is_mul_op || is_div_op);
`endif
  end

  // One iteration step of the datapath plus the sign-corrected final results.
  always_comb begin
    // NOTE: every combinational output gets a value on every path first, so no latch is inferred.
    acc_next  = acc;
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op_b} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift[31:0] - op_b;
    if (is_div) begin
      if (div_shift >= {1'b0, op_b})
        acc_next = {div_diff, acc[30:0], 1'b1};
      else
        acc_next = {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
    end
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_mag;
  logic [63:0] fast_prod;

  // Single-cycle multiplier on magnitudes, sign applied afterwards.
  always_comb begin
    fast_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    fast_prod = (is_signed_op && (a[31] ^ b[31])) ? -fast_mag : fast_mag;
  end
`endif

  // Control FSM, iterative datapath registers and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      op_b   <= 32'd0;
      acc    <= 64'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            cnt    <= 5'd31;
            busy   <= 1'b1;
            is_div <= is_div_op;
            op_b   <= is_div_op ? b_mag : a_mag;
            acc    <= {32'd0, is_div_op ? a_mag : b_mag};
            neg_q  <= is_signed_op && (a[31] ^ b[31]);
            neg_r  <= is_signed_op && a[31];
          end else if (accept) begin
            case (ctl)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
`ifdef MULDIV_FAST_MUL_EN
              OP_MULT, OP_MULTU: begin
                hi   <= fast_prod[63:32];
                lo   <= fast_prod[31:0];
                done <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            if (cnt == 5'd0)
              state <= FIX;
            else
              cnt <= cnt - 5'd1;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = rd_sel ? hi : lo;

endmodule
